if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch stage replacing the single-register PC fetch. It decouples instruction memory from decode with a DEPTH-entry prefetch queue. It supports a request/response memory handshake with variable latency and up to DEPTH outstanding requests. Redirects (taken branch, exception) flush the queue and discard in-flight responses. It sits between instruction memory and the IF/ID pipeline register, and its outputs feed the decode stage directly.

## Interface
- XLEN, default 32: address/instruction width.
- DEPTH, default 4: queue entries, power of two, ≥2; also the maximum outstanding requests.
- RESET_PC, default 0: fetch PC after reset; bits [1:0] must be 0.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  flush and restart fetch at redirect_pc (from EX taken-branch).
- redirect_pc  in  XLEN  new fetch target; bits [1:0] ignored and forced to 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address (fetch_pc).
- imem_resp_valid  in  1  response data valid; responses return in request order.
- imem_resp_data  in  XLEN  instruction word.
- if_ready  in  1  decode consumes the head entry this cycle when if_valid=1.
- if_valid  out  1  head entry valid; when low, if_* outputs are don't-care.
- if_pc  out  XLEN  PC of head instruction.
- if_npc  out  XLEN  if_pc + 4, modulo 2^XLEN.
- if_ir  out  XLEN  head instruction word.

## Operation
- State: fetch_pc; queue of {pc, ir} with head/tail pointers and count (0..DEPTH); outstanding counter (0..DEPTH); drop counter (0..DEPTH).
- Request: imem_req_valid = !rst && !redirect_valid && (count + outstanding < DEPTH). On handshake, outstanding +1 and fetch_pc += 4. The queue slot is reserved by credit, so overflow is impossible.
- Request PC tracking: a side FIFO of DEPTH request PCs is pushed on handshake and popped on every response. The popped PC is the enqueued pc.
- Response: on imem_resp_valid, outstanding −1. If drop > 0, the response is discarded and drop −1. Otherwise {pc, imem_resp_data} is enqueued at the tail.
- Dequeue: when if_valid && if_ready, the head advances and count −1. Simultaneous enqueue and dequeue leaves count unchanged.
- Redirect, at the edge when redirect_valid=1:
  - count ← 0.
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}.
  - drop ← outstanding after this cycle's response decrement, i.e. all responses still in flight are discarded.
  - A response arriving in the redirect cycle is discarded.
  - A dequeue in the redirect cycle is still a valid consume.
  - No request is issued in the redirect cycle.
  - Back-to-back redirects: the last one wins, and the drop count is recomputed each time.
- Combinational outputs: if_valid = (count != 0); if_pc, if_ir, if_npc are taken from the head entry.
- fetch_pc wraps modulo 2^XLEN.

## Timing
- Reset values: fetch_pc=RESET_PC, count=0, outstanding=0, drop=0, if_valid=0, imem_req_valid=0. Outputs if_pc, if_ir and if_npc reset to 0, 0 and 4.
- First request is asserted in the first cycle after rst deasserts.
- Latency:
  - Minimum response latency is 1 cycle after the request handshake.
  - The earliest if_valid is 1 cycle after the response edge, because the response is registered into the queue.
  - Reset-to-first-if_valid is 3 cycles with 1-cycle memory.
- Throughput: one instruction per cycle sustained when memory is 1-cycle and if_ready=1.
- Reset mid-operation: all state is cleared at that edge. Responses arriving after rst deasserts are not dropped, so the memory model must also be reset.
- Queue full with if_ready=0: imem_req_valid stays low until a dequeue frees credit. The request may issue in the cycle after the dequeue edge.

## Test plan
- Reset, then 1-cycle memory returning ir=addr^32'hA5A5_0000, if_ready=1 -> if_valid from cycle 3. if_pc sequence 0,4,8,…, one per cycle, if_npc=if_pc+4.
- DEPTH=4, if_ready=0 for 10 cycles -> exactly 4 requests issued, count=4, imem_req_valid=0. Release if_ready -> PCs 0,4,8,C in order, then fetch resumes at 0x10.
- 3-cycle memory latency, 3 requests outstanding, redirect to 0x103 -> the 3 late responses are dropped, the next request address is 0x100, and the first if_pc after the redirect is 0x100.
- Redirect coincident with a response and with if_ready=1 dequeue -> the response is discarded, the dequeue is counted, and count=0 next cycle.
- Two consecutive redirect cycles (0x200 then 0x300) -> only 0x300 is fetched, and no 0x200 instruction appears.
- fetch_pc near 0xFFFF_FFFC, RESET_PC=32'hFFFF_FFF8 -> addresses FFF8, FFFC, 0000. if_npc for FFFC is 0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: prefetch queue between instruction memory and decode.
// Credits cap requests at DEPTH; a redirect flushes the queue and drops in-flight responses.
module if_fetch_queue #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            if_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_npc,
  output logic [XLEN-1:0] if_ir
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [AW-1:0]   rp_head_q, rp_tail_q;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] ir_mem_q [DEPTH];
  logic [XLEN-1:0] rp_mem_q [DEPTH];

  logic [CW:0] inflight;
  logic        req_hs, deq, enq;

  // Queue slots are reserved at request time, so responses can never overflow it.
  assign inflight       = {1'b0, count_q} + {1'b0, out_q};
  assign imem_req_valid = !rst && !redirect_valid && (inflight < DEPTH_L);
  assign imem_req_addr  = fetch_pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign if_valid = (count_q != '0);
  assign if_pc    = pc_mem_q[head_q];
  assign if_ir    = ir_mem_q[head_q];
  assign if_npc   = if_pc + XLEN'(4);

  assign deq = if_valid && if_ready;
  assign enq = imem_resp_valid && !redirect_valid && (drop_q == '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q + CW'(enq) - CW'(deq);
    out_d      = out_q + CW'(req_hs) - CW'(imem_resp_valid);
    drop_d     = drop_q;
    head_d     = deq ? head_q + AW'(1) : head_q;
    tail_d     = enq ? tail_q + AW'(1) : tail_q;
    if (req_hs)
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (imem_resp_valid && drop_q != '0)
      drop_d = drop_q - CW'(1);
    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      drop_d     = out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      rp_head_q  <= '0;
      rp_tail_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i] <= '0;
        ir_mem_q[i] <= '0;
        rp_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (req_hs) begin
        rp_mem_q[rp_tail_q] <= fetch_pc_q;
        rp_tail_q           <= rp_tail_q + AW'(1);
      end
      // Request-PC FIFO pops on every response, dropped or not, to stay in order.
      if (imem_resp_valid)
        rp_head_q <= rp_head_q + AW'(1);
      if (enq) begin
        pc_mem_q[tail_q] <= rp_mem_q[rp_head_q];
        ir_mem_q[tail_q] <= imem_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a queue-based reference model and in-order memory models.
module tb_if_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect_valid, imem_req_ready, if_ready;
  logic [31:0] redirect_pc;
  logic        req_valid, resp_valid, if_valid;
  logic [31:0] req_addr, resp_data, if_pc, if_npc, if_ir;
  logic        req_valid2, resp_valid2, if_valid2;
  logic [31:0] req_addr2, resp_data2, if_pc2, if_npc2, if_ir2;

  if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data), .if_ready(if_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_npc(if_npc), .if_ir(if_ir));

  if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(req_valid2), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr2),
    .imem_resp_valid(resp_valid2), .imem_resp_data(resp_data2), .if_ready(if_ready),
    .if_valid(if_valid2), .if_pc(if_pc2), .if_npc(if_npc2), .if_ir(if_ir2));

  typedef struct { logic [31:0] pc; logic [31:0] ir; } ent_t;
  typedef struct { logic [31:0] a; int due; } mreq_t;

  int errors = 0, checks = 0;
  int cyc = 0, tcount = 0, lat = 1;

  ent_t        mq[$];
  logic [31:0] m_out[$];
  int          m_drop;
  logic [31:0] m_fpc;
  bit          m_known = 0;
  mreq_t       memq[$], mem2q[$];

  logic        obs_hs, obs_deq, obs_ivld, obs_vld, obs_hs2;
  logic [31:0] obs_addr, obs_pc, obs_addr2;
  logic [31:0] hs_log[$], deq_log[$], deq_cyc_log[$], hs2_log[$], deq2_log[$], npc2_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] getq(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    hs_log.delete(); deq_log.delete(); deq_cyc_log.delete();
    hs2_log.delete(); deq2_log.delete(); npc2_log.delete();
    tcount = 0;
  endtask

  task automatic tick();
    logic        exp_rv, m_hs;
    logic [31:0] p;
    tcount++;
    if (memq.size() > 0 && memq[0].due == cyc) begin
      resp_valid = 1'b1; resp_data = memq[0].a ^ 32'hA5A5_0000;
    end else begin
      resp_valid = 1'b0; resp_data = '0;
    end
    if (mem2q.size() > 0 && mem2q[0].due == cyc) begin
      resp_valid2 = 1'b1; resp_data2 = mem2q[0].a ^ 32'hA5A5_0000;
    end else begin
      resp_valid2 = 1'b0; resp_data2 = '0;
    end
    @(negedge clk);
    obs_vld  = req_valid;  obs_addr = req_addr;  obs_hs  = req_valid && imem_req_ready;
    obs_ivld = if_valid;   obs_pc   = if_pc;     obs_deq = if_valid && if_ready;
    obs_addr2 = req_addr2; obs_hs2  = req_valid2 && imem_req_ready;
    if (obs_hs) hs_log.push_back(obs_addr);
    if (obs_deq) begin deq_log.push_back(obs_pc); deq_cyc_log.push_back(tcount); end
    if (obs_hs2) hs2_log.push_back(obs_addr2);
    if (if_valid2 && if_ready) begin deq2_log.push_back(if_pc2); npc2_log.push_back(if_npc2); end
    exp_rv = !rst && !redirect_valid && (mq.size() + m_out.size() < DEPTH);
    m_hs   = exp_rv && imem_req_ready;
    if (m_known) begin
      chk("req_valid", {31'b0, req_valid}, {31'b0, exp_rv});
      if (exp_rv) chk("req_addr", req_addr, m_fpc);
      chk("if_valid", {31'b0, if_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("if_pc", if_pc, mq[0].pc);
        chk("if_ir", if_ir, mq[0].ir);
        chk("if_npc", if_npc, mq[0].pc + 32'd4);
      end
    end
    @(posedge clk);
    if (rst) begin
      mq.delete(); m_out.delete(); m_drop = 0; m_fpc = 32'h0; m_known = 1;
      memq.delete(); mem2q.delete();
    end else begin
      if (m_known) begin
        if (mq.size() != 0 && if_ready) void'(mq.pop_front());
        if (resp_valid && m_out.size() != 0) begin
          p = m_out.pop_front();
          if (!redirect_valid) begin
            if (m_drop > 0) m_drop--;
            else mq.push_back('{pc: p, ir: resp_data});
          end
        end
        if (m_hs) begin m_out.push_back(m_fpc); m_fpc = m_fpc + 32'd4; end
        if (redirect_valid) begin
          mq.delete(); m_fpc = redirect_pc & ~32'h3; m_drop = m_out.size();
        end
      end
      if (resp_valid) void'(memq.pop_front());
      if (obs_hs) memq.push_back('{a: obs_addr, due: cyc + lat});
      if (resp_valid2) void'(mem2q.pop_front());
      if (obs_hs2) mem2q.push_back('{a: obs_addr2, due: cyc + lat});
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0;
    tick(); tick();
    chk("rst_req_valid", {31'b0, obs_vld}, 32'd0);
    chk("rst_if_valid", {31'b0, obs_ivld}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_ir", if_ir, 32'h0);
    chk("rst_if_npc", if_npc, 32'h4);
    rst = 1'b0;
  endtask

  initial begin
    int bad;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; if_ready = 1'b1;
    resp_valid = 1'b0; resp_data = '0; resp_valid2 = 1'b0; resp_data2 = '0;

    // 1-cycle memory, streaming decode
    lat = 1; if_ready = 1'b1;
    do_reset(); clear_logs();
    repeat (10) tick();
    chk("first_valid_cycle", getq(deq_cyc_log, 0), 32'd3);
    for (int k = 0; k < 6; k++) begin
      chk("stream_pc", getq(deq_log, k), 32'(4 * k));
      chk("stream_cycle", getq(deq_cyc_log, k), 32'(3 + k));
    end

    // Decode stalled: queue fills with exactly DEPTH entries
    do_reset(); clear_logs(); if_ready = 1'b0;
    repeat (10) tick();
    chk("full_hs_count", 32'(hs_log.size()), 32'd4);
    chk("full_req_valid", {31'b0, obs_vld}, 32'd0);
    chk("full_if_valid", {31'b0, obs_ivld}, 32'd1);
    if_ready = 1'b1;
    repeat (8) tick();
    chk("drain_pc0", getq(deq_log, 0), 32'h0);
    chk("drain_pc1", getq(deq_log, 1), 32'h4);
    chk("drain_pc2", getq(deq_log, 2), 32'h8);
    chk("drain_pc3", getq(deq_log, 3), 32'hC);
    chk("resume_addr", getq(hs_log, 4), 32'h10);

    // 3-cycle memory, redirect with 3 requests outstanding
    do_reset(); lat = 3;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0; clear_logs();
    repeat (15) tick();
    chk("redir_first_req", getq(hs_log, 0), 32'h100);
    chk("redir_first_pc", getq(deq_log, 0), 32'h100);
    bad = 0;
    foreach (deq_log[i]) if (deq_log[i] < 32'h100) bad++;
    chk("redir_stale_pcs", 32'(bad), 32'd0);

    // Redirect coincident with a response and a dequeue
    do_reset(); lat = 1;
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick();
    chk("coinc_deq", {31'b0, obs_deq}, 32'd1);
    chk("coinc_deq_pc", obs_pc, 32'hC);
    redirect_valid = 1'b0;
    tick();
    chk("coinc_empty", {31'b0, obs_ivld}, 32'd0);
    clear_logs();
    repeat (10) tick();
    chk("coinc_first_pc", getq(deq_log, 0), 32'h400);

    // Back-to-back redirects: last one wins
    do_reset();
    repeat (5) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200; tick();
    redirect_pc = 32'h300; tick();
    redirect_valid = 1'b0; clear_logs();
    repeat (12) tick();
    chk("b2b_first_req", getq(hs_log, 0), 32'h300);
    chk("b2b_first_pc", getq(deq_log, 0), 32'h300);
    bad = 0;
    foreach (deq_log[i]) if (deq_log[i] >= 32'h200 && deq_log[i] < 32'h300) bad++;
    chk("b2b_no_0x200", 32'(bad), 32'd0);

    // PC wrap on the second instance
    do_reset(); clear_logs();
    repeat (8) tick();
    chk("wrap_req0", getq(hs2_log, 0), 32'hFFFF_FFF8);
    chk("wrap_req1", getq(hs2_log, 1), 32'hFFFF_FFFC);
    chk("wrap_req2", getq(hs2_log, 2), 32'h0000_0000);
    chk("wrap_pc1", getq(deq2_log, 1), 32'hFFFF_FFFC);
    chk("wrap_npc1", getq(npc2_log, 1), 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
